// File: rtl/sreg_serial_loop_ctrl_if.sv
// Word-side handshake bundle for sreg_serial_loop_ctrl: send channel in, recaptured channel out.
interface sreg_serial_loop_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/sreg_serial_loop_ctrl.sv
// Shifts a word LSB-first through an external ce/si/so delay line and recaptures it on so.
// Optional SREG_CTRL_LOOP_CHECK_EN adds a sticky `mismatch` flag comparing returned and sent words.
module sreg_serial_loop_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SREG_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sreg_serial_loop_ctrl_if.slave bus,
  input  logic                   hold,
  output logic                   sreg_ce,
  output logic                   sreg_si,
  input  logic                   sreg_so,
  output logic                   busy
`ifdef SREG_CTRL_LOOP_CHECK_EN
  ,
  output logic                   mismatch
`endif
);
  localparam int CW = $clog2(WIDTH + SREG_DEPTH + 1);
  localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_D    = CW'(SREG_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + SREG_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD_OUT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] out_word;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             in_ready;
  logic             step;
  logic             load_out;

  // Written as shift-then-insert so WIDTH=1 needs no special slice.
  function automatic logic [WIDTH-1:0] cap_shift(input logic so, input logic [WIDTH-1:0] cap);
    logic [WIDTH-1:0] r;
    r = cap >> 1;
    r[WIDTH-1] = so;
    return r;
  endfunction

  always_comb begin
    in_ready = rst_n && (state == IDLE) && !out_valid_q;
    step     = (state == RUN) && !hold;
    sreg_ce  = step;
    sreg_si  = ((state == RUN) && (cnt < CNT_W)) ? shift_q[0] : 1'b0;
    busy     = (state == RUN);
    cap_next = cap_shift(sreg_so, cap_q);
    load_out = !out_valid_q && ((step && (cnt == CNT_LAST)) || (state == HOLD_OUT));
    out_word = (state == HOLD_OUT) ? cap_q : cap_next;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            shift_q <= bus.in_data;
            cnt     <= '0;
            cap_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!hold) begin
            cnt <= cnt + CW'(1);
            if (cnt < CNT_W)
              shift_q <= shift_q >> 1;
            // Captures before SREG_DEPTH would only see stale line contents.
            if (cnt >= CNT_D)
              cap_q <= cap_next;
            if (cnt == CNT_LAST) begin
              if (load_out) begin
                out_data_q  <= out_word;
                out_valid_q <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= HOLD_OUT;
              end
            end
          end
        end
        HOLD_OUT: begin
          if (load_out) begin
            out_data_q  <= out_word;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SREG_CTRL_LOOP_CHECK_EN
  logic [WIDTH-1:0] sent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q   <= '0;
      mismatch <= 1'b0;
    end else begin
      if (bus.in_valid && in_ready)
        sent_q <= bus.in_data;
      if (load_out && (out_word != sent_q))
        mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sreg_serial_loop_ctrl.sv
// Directed bench for sreg_serial_loop_ctrl driving a behavioural 8-stage shift register.
module tb_sreg_serial_loop_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic hold;
  logic sreg_ce, sreg_si, sreg_so;
  logic busy;
  logic fault;
  logic [7:0] line;
`ifdef SREG_CTRL_LOOP_CHECK_EN
  logic mismatch;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sreg_serial_loop_ctrl_if #(.WIDTH(8)) bus_if ();

  sreg_serial_loop_ctrl #(.WIDTH(8), .SREG_DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .hold    (hold),
    .sreg_ce (sreg_ce),
    .sreg_si (sreg_si),
    .sreg_so (sreg_so),
    .busy    (busy)
`ifdef SREG_CTRL_LOOP_CHECK_EN
    ,
    .mismatch(mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Delay line: stage 0 takes si, so is the last stage; not touched by reset.
  always @(posedge clk)
    if (sreg_ce) line <= {line[6:0], sreg_si};
  assign sreg_so = fault ? 1'b0 : line[7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns at negedge+1. lat counts cycles from the accept cycle to out_valid.
  task automatic do_run(input logic [7:0] w, input int hold_step, input int hold_len,
                        input bit hold_last, input int abort_step,
                        output int waits, output int lat, output int ce_cnt,
                        output logic [15:0] si_seq, output int hold_viol);
    int steps, held;
    bit last_done;
    waits = 0; lat = -1; ce_cnt = 0; si_seq = '0; hold_viol = 0;
    steps = 0; held = 0; last_done = 0;
    bus_if.in_data  = w;
    bus_if.in_valid = 1'b1;
    while (!bus_if.in_ready && waits < 40) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!bus_if.in_ready) begin
      bus_if.in_valid = 1'b0;
      return;
    end
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = ~w;
      hold = 1'b0;
      if (steps == hold_step && held < hold_len) begin
        hold = 1'b1;
        held++;
      end else if (hold_last && steps == 15 && !last_done) begin
        hold = 1'b1;
        last_done = 1'b1;
      end
      if (steps == abort_step) begin
        rst_n = 1'b0;
        hold  = 1'b0;
        #1;
        chk("abort_ce", sreg_ce, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", bus_if.out_valid, 0);
        chk("abort_in_ready", bus_if.in_ready, 0);
        return;
      end
      #1;
      if (bus_if.out_valid) begin
        lat  = c;
        hold = 1'b0;
        return;
      end
      if (hold && sreg_ce) hold_viol++;
      if (sreg_ce) begin
        if (steps < 16) si_seq[steps] = sreg_si;
        steps++;
        ce_cnt++;
      end
    end
    hold = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int waits, lat, ce_cnt, hv;
    logic [15:0] si_seq;
    logic [7:0] stream [3];
    stream[0] = 8'h01; stream[1] = 8'h80; stream[2] = 8'hFF;

    rst_n = 1'b0; hold = 1'b0; fault = 1'b0; line = 8'h00;
    bus_if.in_data = 8'h00; bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b1;

    // 1: reset state, then plain A5 run
    @(negedge clk); #1;
    chk("rst_in_ready", bus_if.in_ready, 0);
    chk("rst_ce", sreg_ce, 0);
    chk("rst_si", sreg_si, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_busy", busy, 0);
`ifdef SREG_CTRL_LOOP_CHECK_EN
    chk("rst_mismatch", mismatch, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", bus_if.in_ready, 1);
    do_run(8'hA5, -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t1_wait", waits, 0);
    chk("t1_ce_cycles", ce_cnt, 16);
    chk("t1_si_seq", si_seq, 16'h00A5);
    chk("t1_latency", lat, 17);
    chk("t1_data", bus_if.out_data, 8'hA5);
    @(negedge clk); #1;
    chk("t1_out_valid_fall", bus_if.out_valid, 0);

    // 2: hold 3 cycles at step 5 and 1 cycle at the last step
    do_run(8'hA5, 5, 3, 1, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t2_ce_cycles", ce_cnt, 16);
    chk("t2_ce_in_hold", hv, 0);
    chk("t2_si_seq", si_seq, 16'h00A5);
    chk("t2_latency", lat, 21);
    chk("t2_data", bus_if.out_data, 8'hA5);
    @(negedge clk); #1;

    // 3: output back-pressure blocks the next word
    bus_if.out_ready = 1'b0;
    do_run(8'h3C, -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t3_latency", lat, 17);
    bus_if.in_data  = 8'hFF;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t3_in_ready_blocked", bus_if.in_ready, 0);
      chk("t3_out_valid_held", bus_if.out_valid, 1);
      chk("t3_data_held", bus_if.out_data, 8'h3C);
    end
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(negedge clk); #1;
    chk("t3_out_valid_fall", bus_if.out_valid, 0);
    chk("t3_in_ready_back", bus_if.in_ready, 1);
    do_run(8'hFF, -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t3_ff_wait", waits, 0);
    chk("t3_ff_latency", lat, 17);
    chk("t3_ff_data", bus_if.out_data, 8'hFF);
    @(negedge clk); #1;

    // 4: abort a run of ones at step 6, then send zeros through the dirty line
    do_run(8'hFF, -1, 0, 0, 6, waits, lat, ce_cnt, si_seq, hv);
    chk("t4_prefill", line, 8'h3F);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t4_rst_ce", sreg_ce, 0);
      chk("t4_rst_out_valid", bus_if.out_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t4_no_out_valid", bus_if.out_valid, 0);
      chk("t4_idle", busy, 0);
    end
    do_run(8'h00, -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t4_latency", lat, 17);
    chk("t4_data", bus_if.out_data, 8'h00);

    // 5: back-to-back stream with out_ready tied high
    for (int i = 0; i < 3; i++) begin
      do_run(stream[i], -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
      chk("t5_turnaround", waits, 1);
      chk("t5_latency", lat, 17);
      chk("t5_data", bus_if.out_data, {24'h0, stream[i]});
    end
`ifdef SREG_CTRL_LOOP_CHECK_EN
    chk("t5_mismatch_clear", mismatch, 0);
`endif
    @(negedge clk); #1;

    // 6: stuck-at-0 so; loop check is sticky and cleared only by reset
    fault = 1'b1;
    do_run(8'h81, -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t6_fault_data", bus_if.out_data, 8'h00);
`ifdef SREG_CTRL_LOOP_CHECK_EN
    chk("t6_mismatch_set", mismatch, 1);
`endif
    fault = 1'b0;
    @(negedge clk); #1;
    do_run(8'h81, -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t6_good_data", bus_if.out_data, 8'h81);
`ifdef SREG_CTRL_LOOP_CHECK_EN
    chk("t6_mismatch_sticky", mismatch, 1);
`endif
    do_reset();
`ifdef SREG_CTRL_LOOP_CHECK_EN
    chk("t6_mismatch_rst", mismatch, 0);
`endif
    do_run(8'h81, -1, 0, 0, -1, waits, lat, ce_cnt, si_seq, hv);
    chk("t6_clean_data", bus_if.out_data, 8'h81);
    chk("t6_clean_latency", lat, 17);
`ifdef SREG_CTRL_LOOP_CHECK_EN
    chk("t6_mismatch_clean", mismatch, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
